// File: rtl/ysyx_210544_cache_line_xfer_pkg.sv
// rtl/ysyx_210544_cache_line_xfer_pkg.sv - shared constants and types for the cache line transfer engine
package ysyx_210544_cache_line_xfer_pkg;

    // AXI size codes: word for the narrow region, doubleword for a 64-bit bus
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [2:0] SIZE_D = 3'd3;

    // addr[31:28] value that marks the narrow (flash) region
    localparam logic [3:0] NARROW_TAG_DFLT = 4'h3;

    // FSM state encodings
    localparam logic [1:0] XFER_IDLE = 2'd0;
    localparam logic [1:0] XFER_BUSY = 2'd1;
    localparam logic [1:0] XFER_ACK  = 2'd2;
    localparam logic [1:0] XFER_WAIT = 2'd3;

    // request attributes captured when leaving IDLE
    typedef struct packed {
        logic op;
        logic narrow;
    } xfer_req_t;

    // line-aligned base address: clear the offset bits within one line
    function automatic logic [63:0] line_base(input logic [63:0] addr, input int line_bytes);
        return addr & ~(64'(line_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/ysyx_210544_cache_line_xfer_if.sv
// rtl/ysyx_210544_cache_line_xfer_if.sv - cache-side and AXI-side signal bundle of the line transfer engine
interface ysyx_210544_cache_line_xfer_if #(
    parameter int LINE_W = 512,
    parameter int BUS_W  = 64
);
    logic              i_cache_req;
    logic              i_cache_op;
    logic [63:0]       i_cache_addr;
    logic [LINE_W-1:0] i_cache_wdata;
    logic [LINE_W-1:0] o_cache_rdata;
    logic              o_cache_ack;
    logic              o_cache_err;

    logic              o_axi_valid;
    logic              i_axi_ready;
    logic              o_axi_op;
    logic [63:0]       o_axi_addr;
    logic [BUS_W-1:0]  o_axi_wdata;
    logic [BUS_W-1:0]  i_axi_rdata;
    logic              i_axi_err;
    logic [2:0]        o_axi_size;
    logic [7:0]        o_axi_blks;

    // engine view
    modport slave (
        input  i_cache_req, i_cache_op, i_cache_addr, i_cache_wdata,
        input  i_axi_ready, i_axi_rdata, i_axi_err,
        output o_cache_rdata, o_cache_ack, o_cache_err,
        output o_axi_valid, o_axi_op, o_axi_addr, o_axi_wdata, o_axi_size, o_axi_blks
    );

    // environment view (cache controller plus AXI bridge)
    modport master (
        output i_cache_req, i_cache_op, i_cache_addr, i_cache_wdata,
        output i_axi_ready, i_axi_rdata, i_axi_err,
        input  o_cache_rdata, o_cache_ack, o_cache_err,
        input  o_axi_valid, o_axi_op, o_axi_addr, o_axi_wdata, o_axi_size, o_axi_blks
    );
endinterface

// File: rtl/ysyx_210544_cache_line_xfer_beat_mux.sv
// rtl/ysyx_210544_cache_line_xfer_beat_mux.sv - selects write beat k out of a cache line
module ysyx_210544_line_beat_mux #(
    parameter int LINE_W   = 512,
    parameter int BUS_W    = 64,
    parameter int NARROW_W = 32,
    parameter int K_W      = 4
) (
    input  logic [LINE_W-1:0] line,
    input  logic [K_W-1:0]    k,
    input  logic              narrow,
    output logic [BUS_W-1:0]  beat
);
    localparam int NW = LINE_W / NARROW_W;
    localparam int NB = LINE_W / BUS_W;

    // narrow words sit zero-extended in the low lanes; normal beats use the full bus
    always_comb begin
        beat = '0;
        if (narrow) begin
            for (int i = 0; i < NW; i++) begin
                if (int'(k) == i) beat[NARROW_W-1:0] = line[i*NARROW_W +: NARROW_W];
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (int'(k) == i) beat = line[i*BUS_W +: BUS_W];
            end
        end
    end
endmodule

// File: rtl/ysyx_210544_cache_line_xfer.sv
// rtl/ysyx_210544_cache_line_xfer.sv - moves one cache line between the cache controller and the AXI bridge
module ysyx_210544_cache_line_xfer
    import ysyx_210544_cache_line_xfer_pkg::*;
#(
    parameter int         LINE_W     = 512,
    parameter int         BUS_W      = 64,
    parameter int         NARROW_W   = 32,
    parameter logic [3:0] NARROW_TAG = NARROW_TAG_DFLT
) (
    input logic                         clk,
    input logic                         rst,
    ysyx_210544_cache_line_xfer_if.slave bus
);
    localparam int NW    = LINE_W / NARROW_W;
    localparam int NB    = LINE_W / BUS_W;
    localparam int WI_W  = $clog2(NW);
    localparam int CNT_W = WI_W + 1;
    localparam logic [CNT_W-1:0] LAST_N = CNT_W'(NW - 1);
    localparam logic [CNT_W-1:0] LAST_D = CNT_W'(NB - 1);
    localparam logic [7:0]       BLKS_D = 8'(NB - 1);
    localparam logic [2:0]       SIZE_BUS = (BUS_W == 64) ? SIZE_D : SIZE_W;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              err_q;
    xfer_req_t         req_q;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] rdata_q;
    logic [63:0]       addr_q;
    logic [BUS_W-1:0]  wbeat;
    logic              hs;
    logic              last;

    assign hs   = (state == XFER_BUSY) && bus.i_axi_ready;
    assign last = (cnt == (req_q.narrow ? LAST_N : LAST_D));

    // control FSM: latch the request, step through the beats, pulse ack, then wait for req to drop
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= XFER_IDLE;
            cnt    <= '0;
            err_q  <= 1'b0;
            req_q  <= '0;
            line_q <= '0;
            addr_q <= '0;
        end else begin
            case (state)
                XFER_IDLE: begin
                    if (bus.i_cache_req) begin
                        state        <= XFER_BUSY;
                        cnt          <= '0;
                        err_q        <= 1'b0;
                        req_q.op     <= bus.i_cache_op;
                        req_q.narrow <= (bus.i_cache_addr[31:28] == NARROW_TAG);
                        addr_q       <= line_base(bus.i_cache_addr, LINE_W / 8);
                        line_q       <= bus.i_cache_wdata;
                    end
                end
                XFER_BUSY: begin
                    if (hs) begin
                        cnt   <= cnt + CNT_W'(1);
                        err_q <= err_q | bus.i_axi_err;
                        // narrow region issues one single-word transaction per beat
                        if (req_q.narrow) addr_q <= addr_q + 64'd4;
                        if (last) state <= XFER_ACK;
                    end
                end
                XFER_ACK: state <= XFER_WAIT;
                default: begin
                    if (!bus.i_cache_req) state <= XFER_IDLE;
                end
            endcase
        end
    end

    // assemble the read line one beat at a time in each handshake cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (hs && !req_q.op) begin
            for (int i = 0; i < NW; i++) begin
                if (req_q.narrow && int'(cnt) == i)
                    rdata_q[i*NARROW_W +: NARROW_W] <= bus.i_axi_rdata[NARROW_W-1:0];
            end
            for (int i = 0; i < NB; i++) begin
                if (!req_q.narrow && int'(cnt) == i)
                    rdata_q[i*BUS_W +: BUS_W] <= bus.i_axi_rdata;
            end
        end
    end

    ysyx_210544_line_beat_mux #(
        .LINE_W  (LINE_W),
        .BUS_W   (BUS_W),
        .NARROW_W(NARROW_W),
        .K_W     (WI_W)
    ) u_beat_mux (
        .line  (line_q),
        .k     (cnt[WI_W-1:0]),
        .narrow(req_q.narrow),
        .beat  (wbeat)
    );

    assign bus.o_axi_valid   = (state == XFER_BUSY);
    assign bus.o_cache_ack   = (state == XFER_ACK);
    assign bus.o_cache_err   = (state == XFER_ACK) && err_q;
    assign bus.o_cache_rdata = rdata_q;
    assign bus.o_axi_op      = req_q.op;
    assign bus.o_axi_addr    = addr_q;
    assign bus.o_axi_wdata   = wbeat;
    assign bus.o_axi_size    = req_q.narrow ? SIZE_W : SIZE_BUS;
    assign bus.o_axi_blks    = req_q.narrow ? 8'd0 : BLKS_D;
endmodule
